// File: rtl/imem_boot_sequencer.sv
// imem_boot_sequencer
//   Loads a program into the RISC-V core's instruction memory from a
//   valid/ready word stream, then releases the core from reset to run it.
//   The core is held in reset at all times except in RUN.
//
// Ports
//   i_clock, i_reset      clock; asynchronous active-high reset
//   i_start, i_abort      begin (re)load / return to idle (abort wins)
//   i_word_valid/_data/_last, o_word_ready   instruction word stream
//   o_core_reset          core reset
//   o_imem_load           core reset_IF_memory (memory write mode)
//   o_imem_addr           core PC_write (byte address)
//   o_imem_data           core instruction_in
//   o_words_loaded        words accepted in the current/last load
//   o_busy, o_done, o_overflow   status: loading / running / program too big
//
// state   | meaning
// IDLE    | core held in reset, waiting for start
// LOAD    | accepting words, each written to imem at the write pointer
// FLUSH   | one extra write cycle for the final word
// RELEASE | core still in reset, memory write off, counting down
// RUN     | core released
// ERROR   | program exceeded memory capacity; sticky until start/abort

module imem_boot_sequencer #(
  parameter int PC_SIZE        = 10,
  parameter int ADDR_STEP      = 4,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_word_valid,
  input  logic [31:0]        i_word_data,
  input  logic               i_word_last,
  output logic               o_word_ready,
  output logic               o_core_reset,
  output logic               o_imem_load,
  output logic [PC_SIZE-1:0] o_imem_addr,
  output logic [31:0]        o_imem_data,
  output logic [PC_SIZE:0]   o_words_loaded,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow
);

  localparam int CAP  = (2 ** PC_SIZE) / ADDR_STEP;
  localparam int RC_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  localparam logic [PC_SIZE:0]   LAST_SLOT = (PC_SIZE + 1)'(CAP - 1);
  localparam logic [PC_SIZE-1:0] STEP      = PC_SIZE'(ADDR_STEP);
  localparam logic [RC_W-1:0]    RC_INIT   = RC_W'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RELEASE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic [PC_SIZE-1:0] r_wptr;
  logic [RC_W-1:0]    r_rel_cnt;

  logic               r_word_ready;
  logic               r_core_reset;
  logic               r_imem_load;
  logic [PC_SIZE-1:0] r_imem_addr;
  logic [31:0]        r_imem_data;
  logic [PC_SIZE:0]   r_words_loaded;
  logic               r_busy;
  logic               r_done;
  logic               r_overflow;

  always_comb begin
    w_next   = r_state;
    // an abort in the same cycle discards the beat
    w_accept = r_word_ready && i_word_valid && !i_abort;
    if (i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (i_start) w_next = S_LOAD;
        S_LOAD: begin
          if (w_accept) begin
            if (i_word_last)                       w_next = S_FLUSH;
            else if (r_words_loaded == LAST_SLOT)  w_next = S_ERROR;
          end
        end
        S_FLUSH:   w_next = S_RELEASE;
        S_RELEASE: if (r_rel_cnt == '0) w_next = S_RUN;
        S_RUN:     if (i_start) w_next = S_LOAD;
        S_ERROR:   if (i_start) w_next = S_LOAD;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Status/control outputs are decoded from the next state so they are
  // registered yet line up with the state they describe.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_wptr         <= '0;
      r_rel_cnt      <= '0;
      r_word_ready   <= 1'b0;
      r_core_reset   <= 1'b1;
      r_imem_load    <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_data    <= '0;
      r_words_loaded <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_word_ready <= (w_next == S_LOAD);
      r_core_reset <= (w_next != S_RUN);
      r_imem_load  <= (w_next == S_LOAD) || (w_next == S_FLUSH);
      r_busy       <= (w_next == S_LOAD) || (w_next == S_FLUSH) || (w_next == S_RELEASE);
      r_done       <= (w_next == S_RUN);
      r_overflow   <= (w_next == S_ERROR);

      if ((w_next == S_RELEASE) && (r_state != S_RELEASE))
        r_rel_cnt <= RC_INIT;
      else if ((r_state == S_RELEASE) && (r_rel_cnt != '0))
        r_rel_cnt <= r_rel_cnt - 1'b1;

      if ((w_next == S_LOAD) && (r_state != S_LOAD)) begin
        r_wptr         <= '0;
        r_imem_addr    <= '0;
        r_imem_data    <= '0;
        r_words_loaded <= '0;
      end else if (w_accept) begin
        r_imem_addr    <= r_wptr;
        r_imem_data    <= i_word_data;
        r_wptr         <= r_wptr + STEP;
        r_words_loaded <= r_words_loaded + 1'b1;
      end
    end
  end

  assign o_word_ready   = r_word_ready;
  assign o_core_reset   = r_core_reset;
  assign o_imem_load    = r_imem_load;
  assign o_imem_addr    = r_imem_addr;
  assign o_imem_data    = r_imem_data;
  assign o_words_loaded = r_words_loaded;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_overflow     = r_overflow;

endmodule
